// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared definitions for common-data-bus arbitration.
// This package is also meant for the future multi-CDB arbiter.
package cdb_pkg;

  localparam int N_FU_MAX  = 16;
  localparam int IDX_MAX_W = 4;
  localparam int IDXP_W    = IDX_MAX_W + 1;

  // Encodes a one-hot vector as a binary index. An all-zero vector encodes to 0.
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [N_FU_MAX-1:0] oh);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_FU_MAX; i++) begin
      if (oh[i]) idx = idx | IDX_MAX_W'(i);
    end
    return idx;
  endfunction

  // Scans req starting at ptr and wraps at n-1. Returns {found, index}.
  function automatic logic [IDX_MAX_W:0] rr_pick_idx(input logic [N_FU_MAX-1:0] req,
                                                     input logic [IDX_MAX_W-1:0] ptr,
                                                     input logic [IDXP_W-1:0]    n);
    logic [IDXP_W-1:0]    idx;
    logic                 found;
    logic [IDX_MAX_W-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int off = 0; off < N_FU_MAX; off++) begin
      idx = {1'b0, ptr} + IDXP_W'(off);
      if (idx >= n) idx = idx - n;
      if (!found && (IDXP_W'(off) < n) && req[idx[IDX_MAX_W-1:0]]) begin
        found = 1'b1;
        win   = idx[IDX_MAX_W-1:0];
      end
    end
    return {found, win};
  endfunction

endpackage

// File: rtl/cdb_rr_arbiter_if.sv
// Bus between the functional units and the CDB arbiter.
// Requests flow in, and the registered grant flows out.
interface cdb_rr_arbiter_if #(parameter int N_FU = 3);

  localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [N_FU-1:0]  cdb_req;
  logic [N_FU-1:0]  fu_sel;
  logic [IDX_W-1:0] fu_idx;
  logic             cdb_valid;

  modport master (input cdb_req, output fu_sel, output fu_idx, output cdb_valid);
  modport slave  (output cdb_req, input fu_sel, input fu_idx, input cdb_valid);

endinterface

// File: rtl/cdb_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker. It returns the one-hot first request at or after ptr.
// In fixed mode, the parent drives ptr to 0, which turns this into a lowest-index pick.
module rr_pick
  import cdb_pkg::*;
#(
  parameter int N_FU  = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_FU-1:0]  eff,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_FU-1:0]  pick
);

  logic [IDX_MAX_W:0] res;

  assign res = rr_pick_idx(N_FU_MAX'(eff), IDX_MAX_W'(ptr), IDXP_W'(N_FU));

  always_comb begin
    pick = '0;
    if (res[IDX_MAX_W]) pick = N_FU'(1) << res[IDX_MAX_W-1:0];
  end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Common-data-bus arbiter. It issues one registered one-hot grant per cycle.
// Priority is round-robin or fixed, and a per-FU starvation override forces service.
module cdb_rr_arbiter
  import cdb_pkg::*;
#(
  parameter int N_FU         = 3,
  parameter int RR_MODE      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  cdb_rr_arbiter_if.master     cdb
);

  localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [N_FU-1:0]  fu_sel_q, fu_sel_d;
  logic [IDX_W-1:0] fu_idx_q, fu_idx_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] wait_cnt_q [N_FU];
  logic [CNT_W-1:0] wait_cnt_d [N_FU];

  logic [N_FU-1:0]  eff;
  logic [N_FU-1:0]  rr_oh;
  logic [N_FU-1:0]  starve_oh;
  logic             starve_hit;
  logic [N_FU-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] pick_ptr;

  // The unit granted this cycle is consumed and cannot win the next edge.
  assign eff      = cdb.cdb_req & ~fu_sel_q;
  assign pick_ptr = (RR_MODE != 0) ? ptr_q : '0;

  rr_pick #(.N_FU(N_FU), .IDX_W(IDX_W)) u_rr_pick (
    .eff  (eff),
    .ptr  (pick_ptr),
    .pick (rr_oh)
  );

  always_comb begin
    starve_oh  = '0;
    starve_hit = 1'b0;
    for (int i = 0; i < N_FU; i++) begin
      if (!starve_hit && eff[i] && (wait_cnt_q[i] == CNT_W'(STARVE_LIMIT))) begin
        starve_oh[i] = 1'b1;
        starve_hit   = 1'b1;
      end
    end
  end

  assign grant     = starve_hit ? starve_oh : rr_oh;
  assign grant_idx = IDX_W'(onehot_to_idx(N_FU_MAX'(grant)));

  always_comb begin
    fu_sel_d    = fu_sel_q;
    fu_idx_d    = fu_idx_q;
    cdb_valid_d = cdb_valid_q;
    ptr_d       = ptr_q;
    wait_cnt_d  = wait_cnt_q;
    if (!stall_i) begin
      fu_sel_d    = grant;
      fu_idx_d    = grant_idx;
      cdb_valid_d = |grant;
      if ((RR_MODE != 0) && (|grant)) begin
        ptr_d = (grant_idx == IDX_W'(N_FU - 1)) ? '0 : grant_idx + 1'b1;
      end
      for (int i = 0; i < N_FU; i++) begin
        if (!cdb.cdb_req[i] || grant[i]) begin
          wait_cnt_d[i] = '0;
        end else if (wait_cnt_q[i] != CNT_W'(STARVE_LIMIT)) begin
          wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_sel_q    <= '0;
      fu_idx_q    <= '0;
      cdb_valid_q <= 1'b0;
      ptr_q       <= '0;
      for (int i = 0; i < N_FU; i++) wait_cnt_q[i] <= '0;
    end else begin
      fu_sel_q    <= fu_sel_d;
      fu_idx_q    <= fu_idx_d;
      cdb_valid_q <= cdb_valid_d;
      ptr_q       <= ptr_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign cdb.fu_sel    = fu_sel_q;
  assign cdb.fu_idx    = fu_idx_q;
  assign cdb.cdb_valid = cdb_valid_q;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Bench for cdb_rr_arbiter. It uses three configurations: 3-FU round-robin, 3-FU fixed, and 8-FU round-robin.
// Directed scenarios are followed by random traffic checked against a rule-level model.
module tb_cdb_rr_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [15:0] reqv [3];

  int errors;
  int checks;

  int cfg_n  [3] = '{3, 3, 8};
  int cfg_rr [3] = '{1, 0, 1};

  int m_sel  [3];
  int m_ptr  [3];
  int m_wait [3][16];

  cdb_rr_arbiter_if #(.N_FU(3)) if0 ();
  cdb_rr_arbiter_if #(.N_FU(3)) if1 ();
  cdb_rr_arbiter_if #(.N_FU(8)) if2 ();

  assign if0.cdb_req = reqv[0][2:0];
  assign if1.cdb_req = reqv[1][2:0];
  assign if2.cdb_req = reqv[2][7:0];

  cdb_rr_arbiter #(.N_FU(3), .RR_MODE(1), .STARVE_LIMIT(LIMIT)) dut0 (
    .clk(clk), .rst(rst), .stall_i(stall), .cdb(if0.master));
  cdb_rr_arbiter #(.N_FU(3), .RR_MODE(0), .STARVE_LIMIT(LIMIT)) dut1 (
    .clk(clk), .rst(rst), .stall_i(stall), .cdb(if1.master));
  cdb_rr_arbiter #(.N_FU(8), .RR_MODE(1), .STARVE_LIMIT(LIMIT)) dut2 (
    .clk(clk), .rst(rst), .stall_i(stall), .cdb(if2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] obs_sel(input int d);
    case (d)
      0:       return 16'(if0.fu_sel);
      1:       return 16'(if1.fu_sel);
      default: return 16'(if2.fu_sel);
    endcase
  endfunction

  function automatic int obs_idx(input int d);
    case (d)
      0:       return int'(if0.fu_idx);
      1:       return int'(if1.fu_idx);
      default: return int'(if2.fu_idx);
    endcase
  endfunction

  function automatic logic obs_valid(input int d);
    case (d)
      0:       return if0.cdb_valid;
      1:       return if1.cdb_valid;
      default: return if2.cdb_valid;
    endcase
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_sel[d] = -1;
      m_ptr[d] = 0;
      for (int i = 0; i < 16; i++) m_wait[d][i] = 0;
    end
  endfunction

  // Applies the arbitration rules to one configuration for one clock edge.
  function automatic void model_step(input int d, input logic [15:0] req, input logic stl);
    int n;
    int win;
    int j;
    if (stl) return;
    n   = cfg_n[d];
    win = -1;
    for (int i = 0; i < n; i++)
      if (win < 0 && req[i] && i != m_sel[d] && m_wait[d][i] == LIMIT) win = i;
    if (win < 0) begin
      for (int off = 0; off < n; off++) begin
        j = (cfg_rr[d] != 0) ? (m_ptr[d] + off) % n : off;
        if (win < 0 && req[j] && j != m_sel[d]) win = j;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (!req[i] || i == win) m_wait[d][i] = 0;
      else if (m_wait[d][i] < LIMIT) m_wait[d][i] = m_wait[d][i] + 1;
    end
    m_sel[d] = win;
    if (win >= 0 && cfg_rr[d] != 0) m_ptr[d] = (win + 1) % n;
  endfunction

  function automatic logic [15:0] exp_sel(input int d);
    return (m_sel[d] < 0) ? 16'h0 : (16'h1 << m_sel[d]);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else for (int d = 0; d < 3; d++) model_step(d, reqv[d], stall);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    stall = 1'b0;
    for (int d = 0; d < 3; d++) reqv[d] = '0;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs_sel(d) !== 16'h0 || obs_idx(d) !== 0 || obs_valid(d) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state dut%0d: sel=%h idx=%0d valid=%b expected 0/0/0",
                 d, obs_sel(d), obs_idx(d), obs_valid(d));
      end
    end
    rst = 1'b0;
    reqv[0] = 16'h7;
    tick();
    checks++;
    if (obs_sel(0) !== 16'h1) begin
      errors++;
      $display("[TB] FAIL pre_reset_grant: sel=%h expected 0001", obs_sel(0));
    end
    // Reset is asserted between edges and must clear the outputs immediately.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs_sel(0) !== 16'h0 || obs_idx(0) !== 0 || obs_valid(0) !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: sel=%h idx=%0d valid=%b expected 0/0/0",
               obs_sel(0), obs_idx(0), obs_valid(0));
    end
    reqv[0] = '0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs_sel(0) !== 16'h0 || obs_idx(0) !== 0 || obs_valid(0) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_after_reset cycle %0d: sel=%h idx=%0d valid=%b expected 0/0/0",
                 k, obs_sel(0), obs_idx(0), obs_valid(0));
      end
    end
  endtask

  task automatic test_rr_fairness();
    logic [15:0] exp_seq [6];
    exp_seq = '{16'h1, 16'h2, 16'h4, 16'h1, 16'h2, 16'h4};
    do_reset();
    reqv[0] = 16'h7;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (obs_sel(0) !== exp_seq[k] || obs_idx(0) !== k % 3 || obs_valid(0) !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rr_fairness cycle %0d: sel=%h idx=%0d valid=%b expected %h/%0d/1",
                 k, obs_sel(0), obs_idx(0), obs_valid(0), exp_seq[k], k % 3);
      end
    end
  endtask

  task automatic test_lone_requester();
    logic [15:0] e_sel;
    int          e_idx;
    do_reset();
    reqv[0] = 16'h4;
    for (int k = 0; k < 4; k++) begin
      tick();
      e_sel = (k % 2 == 0) ? 16'h4 : 16'h0;
      e_idx = (k % 2 == 0) ? 2 : 0;
      checks++;
      if (obs_sel(0) !== e_sel || obs_idx(0) !== e_idx || obs_valid(0) !== (e_sel != 0)) begin
        errors++;
        $display("[TB] FAIL lone_requester cycle %0d: sel=%h idx=%0d valid=%b expected %h/%0d",
                 k, obs_sel(0), obs_idx(0), obs_valid(0), e_sel, e_idx);
      end
    end
  endtask

  task automatic test_fixed_starvation();
    logic [15:0] exp_seq [7];
    exp_seq = '{16'h1, 16'h2, 16'h1, 16'h2, 16'h4, 16'h1, 16'h2};
    do_reset();
    reqv[1] = 16'h7;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (obs_sel(1) !== exp_seq[k]) begin
        errors++;
        $display("[TB] FAIL fixed_starvation cycle %0d: sel=%h expected %h", k, obs_sel(1), exp_seq[k]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    reqv[0] = 16'h7;
    tick();
    tick();
    checks++;
    if (obs_sel(0) !== 16'h2) begin
      errors++;
      $display("[TB] FAIL stall_setup: sel=%h expected 0002", obs_sel(0));
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs_sel(0) !== 16'h2 || obs_idx(0) !== 1 || obs_valid(0) !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold edge %0d: sel=%h idx=%0d valid=%b expected 0002/1/1",
                 k, obs_sel(0), obs_idx(0), obs_valid(0));
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (obs_sel(0) !== 16'h4 || obs_idx(0) !== 2) begin
      errors++;
      $display("[TB] FAIL stall_release: sel=%h idx=%0d expected 0004/2", obs_sel(0), obs_idx(0));
    end
  endtask

  task automatic test_width_scaling();
    logic [15:0] e_sel;
    int          e_idx;
    do_reset();
    reqv[2] = 16'h81;
    for (int k = 0; k < 4; k++) begin
      tick();
      e_sel = (k % 2 == 0) ? 16'h01 : 16'h80;
      e_idx = (k % 2 == 0) ? 0 : 7;
      checks++;
      if (obs_sel(2) !== e_sel || obs_idx(2) !== e_idx || obs_valid(2) !== 1'b1) begin
        errors++;
        $display("[TB] FAIL width_scaling cycle %0d: sel=%h idx=%0d valid=%b expected %h/%0d/1",
                 k, obs_sel(2), obs_idx(2), obs_valid(2), e_sel, e_idx);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] e;
    int          ei;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 3; d++) reqv[d] = 16'($urandom) & ((16'h1 << cfg_n[d]) - 16'h1);
      stall = ($urandom_range(0, 9) == 0);
      tick();
      for (int d = 0; d < 3; d++) begin
        e  = exp_sel(d);
        ei = (m_sel[d] < 0) ? 0 : m_sel[d];
        checks++;
        if (obs_sel(d) !== e || obs_idx(d) !== ei || obs_valid(d) !== (e != 0)) begin
          errors++;
          $display("[TB] FAIL random dut%0d cycle %0d: sel=%h idx=%0d valid=%b expected %h/%0d/%b",
                   d, k, obs_sel(d), obs_idx(d), obs_valid(d), e, ei, (e != 0));
        end
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    stall  = 1'b0;
    for (int d = 0; d < 3; d++) reqv[d] = '0;
    model_reset();
    test_reset();
    test_rr_fairness();
    test_lone_requester();
    test_fixed_starvation();
    test_stall();
    test_width_scaling();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_rr_arbiter.md
# cdb_rr_arbiter

Parametrised common-data-bus arbiter for the Tomasulo back end. It sits between the functional units' result-ready requests and the CDB broadcast mux, and supersedes the fixed 3-unit `cdb_arbiter`. It issues one registered one-hot grant per cycle and selects fixed or round-robin priority via a parameter. A per-requester starvation counter forces service of any unit that waits too long, and `stall_i` freezes all arbitration state.

## Interface
- `N_FU`, 3: number of requesting functional units (2..16).
- `RR_MODE`, 1: 1 = round-robin priority, 0 = fixed priority (index 0 highest).
- `STARVE_LIMIT`, 4: wait count at which a requester is force-granted (>= 1).
- `IDX_W`, derived: max(1, $clog2(N_FU)); not overridden.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_i`  in  1  pipeline stall; freezes all state.
- `cdb_req`  in  N_FU  per-FU result-ready request; level, held until granted.
- `fu_sel`  out  N_FU  registered one-hot grant (all-zero = bus idle).
- `fu_idx`  out  IDX_W  binary index of granted FU; 0 when idle.
- `cdb_valid`  out  1  OR of `fu_sel`.

## Operation
- State: `fu_sel` register, `ptr` (IDX_W, round-robin head), `wait_cnt[N_FU]` (each $clog2(STARVE_LIMIT+1) bits, saturating).
- Effective requests are `eff = cdb_req & ~fu_sel`. The FU granted this cycle is consumed and cannot win the next edge. A lone requester with back-to-back results is granted every other cycle.
- Starvation override: if any `wait_cnt[i] == STARVE_LIMIT` with `eff[i]`=1, grant the lowest such i.
- Otherwise, with `RR_MODE`=1: the first set bit of `eff` scanning from `ptr` upward, wrapping at N_FU-1 to 0.
- Otherwise, with `RR_MODE`=0: the lowest set bit of `eff`.
- No effective request: next `fu_sel` = 0.
- On a grant to k: `ptr` <= (k+1) mod N_FU. `ptr` is unchanged when idle or in fixed mode.
- `wait_cnt[i]` update per non-stalled edge:
  - cleared if `cdb_req[i]`=0 or i is granted;
  - else incremented, saturating at STARVE_LIMIT.
- `fu_idx` and `cdb_valid` are registered together with `fu_sel` and are always consistent with it.

## Timing
- Reset (asynchronous assert): `fu_sel`=0, `fu_idx`=0, `cdb_valid`=0, `ptr`=0, all `wait_cnt`=0.
- Latency: request sampled at edge t gives grant visible from t until edge t+1 (one cycle).
- Grant duration: exactly one cycle per win; the FU drops `cdb_req` after the edge ending its grant cycle.
- `stall_i`=1 at an edge: `fu_sel`, `fu_idx`, `cdb_valid`, `ptr` and counters all hold. Requests at that edge are ignored.
- Request dropped without grant: its counter clears; no grant is issued for it.
- Simultaneous starvation of several FUs: lowest index wins; the others keep their saturated counts.
- Reset mid-grant: outputs go to 0 immediately, without waiting for a clock edge.

## Structure
- Shared package `cdb_pkg`: `N_FU_MAX`, a function for the one-hot-to-index encode, and a function for the rotating priority pick. These are reused by the future multi-CDB arbiter.
- One natural sub-module: `rr_pick`. It is combinational, takes `eff` and `ptr`, and returns a one-hot result; fixed mode drives `ptr`=0.
- Top level holds the registers, the starvation override, and the output encode.

## Test plan
- Reset and idle: assert `rst` mid-cycle with a grant active, then release with `cdb_req`=000 → outputs 0 immediately and remain 000/0/0.
- Round-robin fairness (N_FU=3, RR_MODE=1): `cdb_req`=111 held → `fu_sel` sequence 001, 010, 100, 001, ….
- Lone requester: `cdb_req`=100 held → `fu_sel` 100, 000, 100, 000; `fu_idx`=2 on grant cycles.
- Fixed-mode starvation (RR_MODE=0, STARVE_LIMIT=4): `cdb_req`=111 held → 001, 010, 001, 010, 100, then 001, ….
- Stall: `cdb_req`=111 in RR mode, hold `stall_i`=1 for 3 edges after the 010 grant → `fu_sel` stays 010. Once released, the next grant is 100.
- Width scaling (N_FU=8, RR_MODE=1): `cdb_req`=1000_0001 held → grants alternate 0000_0001 and 1000_0000; `fu_idx` 0 and 7.
